// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch and
// load/store requesters with round-robin grant and a hung-memory watchdog.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   if_req/if_addr    fetch request (level, held until if_done)
//   if_done/if_rdata  fetch completion pulse and held fetched word
//   d_req/d_we/d_be   data request, store flag, store byte enables
//   d_addr/d_wdata    data address and store data
//   d_done/d_rdata    data completion pulse and held load word
//   err               pulses with a done when the watchdog aborted it
//   m_req/m_we/m_be   registered memory request, write strobe, enables
//   m_addr/m_wdata    memory address and write data, stable while m_req
//   m_rdata/m_ready   memory read data and completion handshake
module mem_port_arbiter #(
    parameter int W           = 32,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           if_req,
    input  logic [W-1:0]   if_addr,
    output logic           if_done,
    output logic [W-1:0]   if_rdata,
    input  logic           d_req,
    input  logic           d_we,
    input  logic [W/8-1:0] d_be,
    input  logic [W-1:0]   d_addr,
    input  logic [W-1:0]   d_wdata,
    output logic           d_done,
    output logic [W-1:0]   d_rdata,
    output logic           err,
    output logic           m_req,
    output logic           m_we,
    output logic [W/8-1:0] m_be,
    output logic [W-1:0]   m_addr,
    output logic [W-1:0]   m_wdata,
    input  logic [W-1:0]   m_rdata,
    input  logic           m_ready
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
    typedef enum logic {G_FETCH, G_DATA} grant_e;

    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);
    localparam bit               WD_EN  = (TIMEOUT_CYC != 0);

    state_e           state_q;
    grant_e           gnt_q;
    grant_e           last_q;
    logic [CNT_W-1:0] cnt_q;
    logic             if_done_q, d_done_q, err_q;
    logic             m_req_q, m_we_q;
    logic [W/8-1:0]   m_be_q;
    logic [W-1:0]     m_addr_q, m_wdata_q;
    logic [W-1:0]     if_rdata_q, d_rdata_q;

    grant_e           gnt_d;
    logic [CNT_W-1:0] cnt_d;
    logic             timeout_d;

    // Data wins only when fetch is idle or fetch held the last grant.
    assign gnt_d = (d_req && (!if_req || last_q == G_FETCH)) ? G_DATA
                                                              : G_FETCH;

    // Compare the incremented count so the abort lands in the
    // TIMEOUT_CYC-th BUSY cycle.
    assign cnt_d     = cnt_q + CNT_W'(1);
    assign timeout_d = WD_EN && (cnt_d == TO_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            gnt_q      <= G_FETCH;
            last_q     <= G_DATA;
            cnt_q      <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            err_q      <= 1'b0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_be_q     <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            err_q     <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (if_req || d_req) begin
                        gnt_q   <= gnt_d;
                        last_q  <= gnt_d;
                        cnt_q   <= '0;
                        m_req_q <= 1'b1;
                        if (gnt_d == G_DATA) begin
                            m_we_q    <= d_we;
                            m_be_q    <= d_we ? d_be : '1;
                            m_addr_q  <= d_addr;
                            m_wdata_q <= d_wdata;
                        end else begin
                            m_we_q    <= 1'b0;
                            m_be_q    <= '1;
                            m_addr_q  <= if_addr;
                            m_wdata_q <= '0;
                        end
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_d;
                    if (m_ready || timeout_d) begin
                        m_req_q <= 1'b0;
                        err_q   <= !m_ready;
                        if (gnt_q == G_DATA) begin
                            d_done_q <= 1'b1;
                            if (m_ready && !m_we_q) begin
                                d_rdata_q <= m_rdata;
                            end
                        end else begin
                            if_done_q <= 1'b1;
                            if (m_ready) begin
                                if_rdata_q <= m_rdata;
                            end
                        end
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign if_done  = if_done_q;
    assign d_done   = d_done_q;
    assign err      = err_q;
    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_be     = m_be_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule
